// File: rtl/ext_mem_responder_if.sv
// External-bus bundle between the core (master) and the memory responder (slave).
// It carries the multiplexed ALE/PSEN/RD/WR/P0/P2 bus, the preload port and the status flags.
interface ext_mem_responder_if;
    logic        ale;
    logic        psen_n;
    logic        rd_n;
    logic        wr_n;
    logic [7:0]  p0_in;
    logic [7:0]  p2_in;
    logic [7:0]  p0_out;
    logic        p0_oe;
    logic        ld_en;
    logic        ld_sel;
    logic [15:0] ld_addr;
    logic [7:0]  ld_data;
    logic        busy;
    logic        bus_err;

    modport master (
        output ale, psen_n, rd_n, wr_n, p0_in, p2_in,
        output ld_en, ld_sel, ld_addr, ld_data,
        input  p0_out, p0_oe, busy, bus_err
    );

    modport slave (
        input  ale, psen_n, rd_n, wr_n, p0_in, p2_in,
        input  ld_en, ld_sel, ld_addr, ld_data,
        output p0_out, p0_oe, busy, bus_err
    );
endinterface

// File: rtl/ext_mem_responder.sv
// Memory side of the MCU51 multiplexed external bus.
// It combines an ALE address latch, an external code ROM and an external data RAM, all synchronous to the core clock.
module ext_mem_responder #(
    parameter int CODE_AW = 12,
    parameter int DATA_AW = 8
) (
    input  logic               clk,
    input  logic               reset,
    ext_mem_responder_if.slave bus
);

    localparam int CODE_DEPTH = 1 << CODE_AW;
    localparam int DATA_DEPTH = 1 << DATA_AW;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_LATCHED = 3'd2,
        ST_CODE    = 3'd3,
        ST_DRD     = 3'd4,
        ST_DWR     = 3'd5
    } state_t;

    logic [7:0] rom_r [CODE_DEPTH];
    logic [7:0] ram_r [DATA_DEPTH];

    state_t             state_r;
    state_t             state_s;
    logic [7:0]         addr_lo_r;
    logic [7:0]         wdata_r;
    logic [7:0]         wdata_s;
    logic [7:0]         p0_out_r;
    logic [7:0]         p0_out_s;
    logic               p0_oe_r;
    logic               p0_oe_s;
    logic               busy_r;
    logic               bus_err_r;
    logic               bus_err_s;
    logic               ale_d_r;
    logic               wr_d_r;
    logic               commit_s;
    logic               in_cycle_s;
    logic               own_strobe_n_s;
    logic [15:0]        full_addr_s;
    logic [CODE_AW-1:0] code_addr_s;
    logic [DATA_AW-1:0] data_addr_s;
    logic               unused_s;

    // A strobe conflict exists when any two of the three active-low strobes are asserted together.
    function automatic logic two_low(input logic a_n, input logic b_n, input logic c_n);
        return (!a_n && !b_n) || (!a_n && !c_n) || (!b_n && !c_n);
    endfunction

    assign full_addr_s    = {bus.p2_in, addr_lo_r};
    assign code_addr_s    = full_addr_s[CODE_AW-1:0];
    assign data_addr_s    = full_addr_s[DATA_AW-1:0];
    assign in_cycle_s     = (state_r == ST_CODE) || (state_r == ST_DRD) || (state_r == ST_DWR);
    assign own_strobe_n_s = (state_r == ST_CODE) ? bus.psen_n : bus.rd_n;
    assign unused_s       = ^{bus.ld_addr, full_addr_s};

    assign bus.p0_out  = p0_out_r;
    assign bus.p0_oe   = p0_oe_r;
    assign bus.busy    = busy_r;
    assign bus.bus_err = bus_err_r;

    // Next-state, next-output and write-commit decode for the bus-cycle FSM.
    always_comb begin
        state_s   = state_r;
        p0_out_s  = p0_out_r;
        p0_oe_s   = p0_oe_r;
        bus_err_s = bus_err_r;
        wdata_s   = wdata_r;
        commit_s  = 1'b0;
        if (bus.ale) begin
            // ALE always restarts address capture; inside a live cycle it is an abort.
            state_s = ST_ADDR;
            p0_oe_s = 1'b0;
            if (in_cycle_s) begin
                bus_err_s = 1'b1;
            end else begin
                bus_err_s = bus_err_r;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                ST_ADDR: begin
                    if (ale_d_r) begin
                        state_s = ST_LATCHED;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_LATCHED: begin
                    if (!bus.psen_n) begin
                        state_s  = ST_CODE;
                        p0_out_s = rom_r[code_addr_s];
                        p0_oe_s  = 1'b1;
                        if (!bus.rd_n) begin
                            bus_err_s = 1'b1;
                        end else begin
                            bus_err_s = bus_err_r;
                        end
                    end else if (!bus.rd_n) begin
                        state_s  = ST_DRD;
                        p0_out_s = ram_r[data_addr_s];
                        p0_oe_s  = 1'b1;
                    end else if (!bus.wr_n) begin
                        state_s = ST_DWR;
                        wdata_s = bus.p0_in;
                    end else begin
                        state_s = ST_LATCHED;
                    end
                end
                ST_CODE, ST_DRD: begin
                    if (two_low(bus.psen_n, bus.rd_n, bus.wr_n)) begin
                        bus_err_s = 1'b1;
                    end else begin
                        bus_err_s = bus_err_r;
                    end
                    if (own_strobe_n_s) begin
                        p0_oe_s = 1'b0;
                        state_s = ST_IDLE;
                    end else begin
                        p0_oe_s = 1'b1;
                    end
                end
                ST_DWR: begin
                    if (two_low(bus.psen_n, bus.rd_n, bus.wr_n)) begin
                        bus_err_s = 1'b1;
                    end else begin
                        bus_err_s = bus_err_r;
                    end
                    // The commit uses the value captured on the last low cycle, not the P0 value seen on the rising edge.
                    if (!bus.wr_n) begin
                        wdata_s = bus.p0_in;
                    end else if (!wr_d_r) begin
                        commit_s = 1'b1;
                        state_s  = ST_IDLE;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    p0_oe_s = 1'b0;
                end
            endcase
        end
    end

    // Bus-cycle state, address latch, strobe history and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            addr_lo_r <= 8'h00;
            wdata_r   <= 8'h00;
            p0_out_r  <= 8'h00;
            p0_oe_r   <= 1'b0;
            busy_r    <= 1'b0;
            bus_err_r <= 1'b0;
            ale_d_r   <= 1'b0;
            wr_d_r    <= 1'b1;
        end else begin
            state_r   <= state_s;
            wdata_r   <= wdata_s;
            p0_out_r  <= p0_out_s;
            p0_oe_r   <= p0_oe_s;
            busy_r    <= (state_s == ST_CODE) || (state_s == ST_DRD) || (state_s == ST_DWR);
            bus_err_r <= bus_err_s;
            ale_d_r   <= bus.ale;
            wr_d_r    <= bus.wr_n;
            if (bus.ale) begin
                addr_lo_r <= bus.p0_in;
            end
        end
    end

    // Memory arrays: the preload is written after the commit, so it wins on a same-address collision.
    always_ff @(posedge clk) begin
        if (commit_s) begin
            ram_r[data_addr_s] <= wdata_r;
        end
        if (bus.ld_en && !bus.ld_sel) begin
            ram_r[bus.ld_addr[DATA_AW-1:0]] <= bus.ld_data;
        end
        if (bus.ld_en && bus.ld_sel) begin
            rom_r[bus.ld_addr[CODE_AW-1:0]] <= bus.ld_data;
        end
    end

endmodule

// File: tb/tb_ext_mem_responder.sv
// Randomised scenario bench for ext_mem_responder.
// It checks the responder against a flat array model of the ROM and RAM contents.
module tb_ext_mem_responder;

    localparam int CODE_DEPTH = 4096;
    localparam int DATA_DEPTH = 256;

    logic clk;
    logic reset;
    int   checks;
    int   passes;

    logic [7:0] rom_m [CODE_DEPTH];
    logic [7:0] ram_m [DATA_DEPTH];

    ext_mem_responder_if bus ();

    ext_mem_responder #(.CODE_AW(12), .DATA_AW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int code_idx(input logic [7:0] hi, input logic [7:0] lo);
        return ((int'(hi) * 256) + int'(lo)) % CODE_DEPTH;
    endfunction

    task automatic preload(input logic sel, input logic [15:0] a, input logic [7:0] d);
        bus.ld_en   = 1'b1;
        bus.ld_sel  = sel;
        bus.ld_addr = a;
        bus.ld_data = d;
        step();
        bus.ld_en = 1'b0;
        if (sel) rom_m[int'(a) % CODE_DEPTH] = d;
        else     ram_m[int'(a) % DATA_DEPTH] = d;
    endtask

    // Leaves the responder with the address latched and waiting for a strobe.
    task automatic latch_addr(input logic [7:0] hi, input logic [7:0] lo);
        bus.p2_in = hi;
        bus.p0_in = lo;
        bus.ale   = 1'b1;
        step();
        step();
        bus.ale   = 1'b0;
        bus.p0_in = 8'($urandom);
        step();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        bus.ale = 1'b0; bus.psen_n = 1'b1; bus.rd_n = 1'b1; bus.wr_n = 1'b1;
        bus.p0_in = 8'h00; bus.p2_in = 8'h00;
        bus.ld_en = 1'b0; bus.ld_sel = 1'b0; bus.ld_addr = 16'h0000; bus.ld_data = 8'h00;
        reset = 1'b1;
        #12;
        checks++; if (bus.p0_oe !== 1'b0) $display("FAIL reset_oe got=%b exp=0", bus.p0_oe); else passes++;
        checks++; if (bus.p0_out !== 8'h00) $display("FAIL reset_out got=%h exp=00", bus.p0_out); else passes++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else passes++;
        checks++; if (bus.bus_err !== 1'b0) $display("FAIL reset_err got=%b exp=0", bus.bus_err); else passes++;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_code_fetch();
        logic [7:0]  hi, lo, d;
        logic [15:0] pa;
        for (int i = 0; i < 8; i++) begin
            if (i == 0)      begin hi = 8'h00; lo = 8'h34; d = 8'hA5; pa = 16'h0034; end
            else if (i == 1) begin hi = 8'hF1; lo = 8'h34; d = 8'h5C; pa = 16'h0134; end
            else begin
                hi = 8'($urandom); lo = 8'($urandom); d = 8'($urandom); pa = {hi, lo};
            end
            preload(1'b1, pa, d);
            latch_addr(hi, lo);
            bus.psen_n = 1'b0;
            step();
            checks++; if (bus.p0_oe !== 1'b1) $display("FAIL code_oe got=%b exp=1", bus.p0_oe); else passes++;
            checks++; if (bus.p0_out !== rom_m[code_idx(hi, lo)])
                $display("FAIL code_data addr=%h%h got=%h exp=%h", hi, lo, bus.p0_out, rom_m[code_idx(hi, lo)]);
            else passes++;
            checks++; if (bus.busy !== 1'b1) $display("FAIL code_busy got=%b exp=1", bus.busy); else passes++;
            step();
            step();
            checks++; if (bus.p0_out !== rom_m[code_idx(hi, lo)] || bus.p0_oe !== 1'b1)
                $display("FAIL code_hold got=%h/%b exp=%h/1", bus.p0_out, bus.p0_oe, rom_m[code_idx(hi, lo)]);
            else passes++;
            bus.psen_n = 1'b1;
            step();
            checks++; if (bus.p0_oe !== 1'b0 || bus.busy !== 1'b0)
                $display("FAIL code_end oe/busy got=%b/%b exp=0/0", bus.p0_oe, bus.busy);
            else passes++;
        end
        checks++; if (bus.bus_err !== 1'b0) $display("FAIL code_err got=%b exp=0", bus.bus_err); else passes++;
    endtask

    task automatic read_ram_check(input logic [7:0] a, input logic [7:0] exp, input bit err_exp);
        latch_addr(8'($urandom), a);
        bus.rd_n = 1'b0;
        step();
        checks++; if (bus.p0_oe !== 1'b1 || bus.p0_out !== exp)
            $display("FAIL ram_read addr=%h got=%h/%b exp=%h/1", a, bus.p0_out, bus.p0_oe, exp);
        else passes++;
        checks++; if (bus.bus_err !== err_exp) $display("FAIL ram_read_err got=%b exp=%b", bus.bus_err, err_exp); else passes++;
        bus.rd_n = 1'b1;
        step();
    endtask

    task automatic test_movx();
        logic [7:0] a, wd;
        int         n;
        for (int i = 0; i < 6; i++) begin
            a = (i == 0) ? 8'h20 : 8'($urandom);
            n = (i == 0) ? 2 : int'($urandom_range(1, 4));
            latch_addr(8'($urandom), a);
            bus.wr_n = 1'b0;
            for (int b = 0; b < n; b++) begin
                if (i == 0) wd = (b == 0) ? 8'h11 : 8'h77;
                else        wd = 8'($urandom);
                bus.p0_in = wd;
                step();
                checks++; if (bus.busy !== 1'b1 || bus.p0_oe !== 1'b0)
                    $display("FAIL dwr_beat busy/oe got=%b/%b exp=1/0", bus.busy, bus.p0_oe);
                else passes++;
            end
            bus.wr_n  = 1'b1;
            bus.p0_in = 8'($urandom);
            step();
            ram_m[a] = wd;
            checks++; if (bus.busy !== 1'b0) $display("FAIL dwr_end busy got=%b exp=0", bus.busy); else passes++;
            read_ram_check(a, ram_m[a], 1'b0);
        end
    endtask

    task automatic test_preload_priority();
        logic [7:0] a, x, y;
        a = 8'($urandom);
        x = 8'($urandom);
        y = x ^ 8'h5A;
        latch_addr(8'h00, a);
        bus.wr_n = 1'b0; bus.p0_in = x;
        step();
        bus.wr_n = 1'b1;
        bus.ld_en = 1'b1; bus.ld_sel = 1'b0; bus.ld_addr = {8'($urandom), a}; bus.ld_data = y;
        step();
        bus.ld_en = 1'b0;
        ram_m[a] = y;
        read_ram_check(a, ram_m[a], 1'b0);
        // Commit and preload to different addresses must both land.
        latch_addr(8'h00, a);
        bus.wr_n = 1'b0; bus.p0_in = x;
        step();
        bus.wr_n = 1'b1;
        bus.ld_en = 1'b1; bus.ld_sel = 1'b0; bus.ld_addr = {8'h00, a ^ 8'h01}; bus.ld_data = y;
        step();
        bus.ld_en = 1'b0;
        ram_m[a] = x;
        ram_m[a ^ 8'h01] = y;
        read_ram_check(a, ram_m[a], 1'b0);
        read_ram_check(a ^ 8'h01, ram_m[a ^ 8'h01], 1'b0);
    endtask

    task automatic test_idle_strobe();
        bus.psen_n = 1'b0;
        bus.rd_n   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus.p0_oe !== 1'b0 || bus.busy !== 1'b0 || bus.bus_err !== 1'b0)
                $display("FAIL idle_strobe oe/busy/err got=%b/%b/%b exp=0/0/0", bus.p0_oe, bus.busy, bus.bus_err);
            else passes++;
        end
        bus.psen_n = 1'b1;
        bus.rd_n   = 1'b1;
        step();
    endtask

    task automatic test_conflict();
        logic [7:0] hi, lo;
        hi = 8'($urandom); lo = 8'($urandom);
        preload(1'b1, {hi, lo}, 8'($urandom));
        latch_addr(hi, lo);
        bus.psen_n = 1'b0; bus.rd_n = 1'b0;
        step();
        checks++; if (bus.p0_oe !== 1'b1 || bus.p0_out !== rom_m[code_idx(hi, lo)])
            $display("FAIL conflict_data got=%h/%b exp=%h/1", bus.p0_out, bus.p0_oe, rom_m[code_idx(hi, lo)]);
        else passes++;
        checks++; if (bus.bus_err !== 1'b1) $display("FAIL conflict_err got=%b exp=1", bus.bus_err); else passes++;
        bus.psen_n = 1'b1; bus.rd_n = 1'b1;
        repeat (3) step();
        checks++; if (bus.bus_err !== 1'b1 || bus.busy !== 1'b0)
            $display("FAIL conflict_sticky err/busy got=%b/%b exp=1/0", bus.bus_err, bus.busy);
        else passes++;
        pulse_reset();
        checks++; if (bus.bus_err !== 1'b0) $display("FAIL conflict_clear got=%b exp=0", bus.bus_err); else passes++;
    endtask

    task automatic test_abort();
        logic [7:0] ha, la, hb, lb, a, old_v;
        ha = 8'($urandom); la = 8'($urandom);
        hb = 8'($urandom); lb = la ^ 8'h0F;
        preload(1'b1, {ha, la}, 8'($urandom));
        preload(1'b1, {hb, lb}, rom_m[code_idx(ha, la)] ^ 8'hFF);
        latch_addr(ha, la);
        bus.psen_n = 1'b0;
        step();
        checks++; if (bus.p0_oe !== 1'b1) $display("FAIL abort_pre_oe got=%b exp=1", bus.p0_oe); else passes++;
        bus.ale = 1'b1; bus.p2_in = hb; bus.p0_in = lb;
        step();
        checks++; if (bus.p0_oe !== 1'b0 || bus.busy !== 1'b0 || bus.bus_err !== 1'b1)
            $display("FAIL abort_code oe/busy/err got=%b/%b/%b exp=0/0/1", bus.p0_oe, bus.busy, bus.bus_err);
        else passes++;
        bus.ale = 1'b0; bus.psen_n = 1'b1;
        step();
        bus.psen_n = 1'b0;
        step();
        checks++; if (bus.p0_oe !== 1'b1 || bus.p0_out !== rom_m[code_idx(hb, lb)])
            $display("FAIL abort_relatch got=%h/%b exp=%h/1", bus.p0_out, bus.p0_oe, rom_m[code_idx(hb, lb)]);
        else passes++;
        bus.psen_n = 1'b1;
        step();
        // An aborted write must leave the RAM untouched.
        a = 8'($urandom);
        old_v = 8'($urandom);
        preload(1'b0, {8'h00, a}, old_v);
        latch_addr(8'h00, a);
        bus.wr_n = 1'b0; bus.p0_in = old_v ^ 8'hC3;
        step();
        bus.ale = 1'b1; bus.wr_n = 1'b1; bus.p0_in = a;
        step();
        checks++; if (bus.busy !== 1'b0 || bus.bus_err !== 1'b1)
            $display("FAIL abort_dwr busy/err got=%b/%b exp=0/1", bus.busy, bus.bus_err);
        else passes++;
        bus.ale = 1'b0;
        step();
        bus.rd_n = 1'b0;
        step();
        checks++; if (bus.p0_out !== ram_m[a] || bus.p0_oe !== 1'b1)
            $display("FAIL abort_dwr_ram got=%h/%b exp=%h/1", bus.p0_out, bus.p0_oe, ram_m[a]);
        else passes++;
        bus.rd_n = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_cycle();
        logic [7:0] a, hi, lo;
        a = 8'($urandom);
        preload(1'b0, {8'h00, a}, 8'($urandom));
        latch_addr(8'h00, a);
        bus.rd_n = 1'b0;
        step();
        checks++; if (bus.p0_oe !== 1'b1 || bus.bus_err !== 1'b1)
            $display("FAIL rst_pre oe/err got=%b/%b exp=1/1", bus.p0_oe, bus.bus_err);
        else passes++;
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.p0_oe !== 1'b0 || bus.busy !== 1'b0 || bus.bus_err !== 1'b0)
            $display("FAIL rst_async oe/busy/err got=%b/%b/%b exp=0/0/0", bus.p0_oe, bus.busy, bus.bus_err);
        else passes++;
        bus.rd_n = 1'b1;
        step();
        reset = 1'b0;
        step();
        read_ram_check(a, ram_m[a], 1'b0);
        // A write interrupted by reset is discarded.
        latch_addr(8'h00, a);
        bus.wr_n = 1'b0; bus.p0_in = ram_m[a] ^ 8'h81;
        step();
        #2 reset = 1'b1;
        #1 bus.wr_n = 1'b1;
        step();
        reset = 1'b0;
        step();
        read_ram_check(a, ram_m[a], 1'b0);
        hi = 8'($urandom); lo = 8'($urandom);
        preload(1'b1, {hi, lo}, 8'($urandom));
        latch_addr(hi, lo);
        bus.psen_n = 1'b0;
        step();
        checks++; if (bus.p0_out !== rom_m[code_idx(hi, lo)])
            $display("FAIL rst_rom got=%h exp=%h", bus.p0_out, rom_m[code_idx(hi, lo)]);
        else passes++;
        bus.psen_n = 1'b1;
        step();
    endtask

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_code_fetch();
        test_movx();
        test_preload_priority();
        test_idle_strobe();
        test_conflict();
        test_abort();
        test_reset_mid_cycle();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
